// File: rtl/ring_decoder.sv
// Receive-side decoder for a left-rotating one-hot ring: converts each sample to a
// binary index, tracks lock on the rotation sequence, and counts laps and sequence errors.
module ring_decoder #(
  parameter  int WIDTH  = 4,
  parameter  int LOCK_N = 2,
  parameter  int LAPW   = 8,
  localparam int IDXW   = $clog2(WIDTH)
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Valid_in,
  input  logic [WIDTH-1:0]  Ring_in,
  output logic [IDXW-1:0]   Index_out,
  output logic              Index_valid,
  output logic              Locked,
  output logic              Seq_err,
  output logic [LAPW-1:0]   Lap_count,
  output logic [7:0]        Err_count
);

  localparam int GOODW = $clog2(LOCK_N + 1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // x & (x-1) clears the lowest set bit, so a non-zero x is one-hot exactly when it yields zero
  function automatic logic is_one_hot(input logic [WIDTH-1:0] v);
    return (v != {WIDTH{1'b0}}) && ((v & (v - WIDTH'(1))) == {WIDTH{1'b0}});
  endfunction

  function automatic logic [IDXW-1:0] encode(input logic [WIDTH-1:0] v);
    logic [IDXW-1:0] idx;
    idx = {IDXW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        idx = idx | IDXW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_t            state_r, state_s;
  logic [IDXW-1:0]   ref_r, ref_s;
  logic [GOODW-1:0]  good_r, good_s;
  logic [IDXW-1:0]   index_r, index_s;
  logic              index_valid_r, index_valid_s;
  logic              locked_r, locked_s;
  logic              seq_err_r, seq_err_s;
  logic [LAPW-1:0]   lap_r, lap_s;
  logic [7:0]        err_r, err_s;

  logic              one_hot_s;
  logic [IDXW-1:0]   sample_idx_s;
  logic [IDXW-1:0]   expected_s;
  logic [GOODW-1:0]  good_inc_s;
  logic [7:0]        err_inc_s;

  // Sample decode, expected successor of ref and saturating error increment
  always_comb begin
    one_hot_s    = is_one_hot(Ring_in);
    sample_idx_s = encode(Ring_in);
    if (ref_r == IDXW'(WIDTH - 1)) begin
      expected_s = {IDXW{1'b0}};
    end else begin
      expected_s = ref_r + IDXW'(1);
    end
    good_inc_s = good_r + GOODW'(1);
    if (err_r == 8'd255) begin
      err_inc_s = err_r;
    end else begin
      err_inc_s = err_r + 8'd1;
    end
  end

  // Next-state and next-output logic; pulses default low so an idle cycle clears them
  always_comb begin
    state_s       = state_r;
    ref_s         = ref_r;
    good_s        = good_r;
    index_s       = index_r;
    index_valid_s = 1'b0;
    seq_err_s     = 1'b0;
    lap_s         = lap_r;
    err_s         = err_r;

    if (Valid_in) begin
      if (one_hot_s) begin
        index_s       = sample_idx_s;
        index_valid_s = 1'b1;
      end else begin
        index_s       = index_r;
        index_valid_s = 1'b0;
      end

      case (state_r)
        SEARCH: begin
          if (one_hot_s) begin
            ref_s   = sample_idx_s;
            good_s  = {GOODW{1'b0}};
            state_s = ACQUIRE;
          end else begin
            state_s = SEARCH;
          end
        end
        ACQUIRE: begin
          if (!one_hot_s) begin
            state_s = SEARCH;
          end else if (sample_idx_s == expected_s) begin
            ref_s  = sample_idx_s;
            good_s = good_inc_s;
            if (good_inc_s == GOODW'(LOCK_N)) begin
              state_s = LOCKED;
            end else begin
              state_s = ACQUIRE;
            end
          end else begin
            ref_s   = sample_idx_s;
            good_s  = {GOODW{1'b0}};
            state_s = ACQUIRE;
          end
        end
        LOCKED: begin
          if (!one_hot_s) begin
            seq_err_s = 1'b1;
            err_s     = err_inc_s;
            state_s   = SEARCH;
          end else if (sample_idx_s == expected_s) begin
            ref_s = sample_idx_s;
            // a correct step out of the top position is a completed lap
            if (ref_r == IDXW'(WIDTH - 1)) begin
              lap_s = lap_r + LAPW'(1);
            end else begin
              lap_s = lap_r;
            end
          end else begin
            seq_err_s = 1'b1;
            err_s     = err_inc_s;
            ref_s     = sample_idx_s;
            good_s    = {GOODW{1'b0}};
            state_s   = ACQUIRE;
          end
        end
        default: begin
          state_s = SEARCH;
          ref_s   = {IDXW{1'b0}};
          good_s  = {GOODW{1'b0}};
        end
      endcase
    end else begin
      state_s = state_r;
    end

    locked_s = (state_s == LOCKED);
  end

  // State and output registers
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r       <= SEARCH;
      ref_r         <= {IDXW{1'b0}};
      good_r        <= {GOODW{1'b0}};
      index_r       <= {IDXW{1'b0}};
      index_valid_r <= 1'b0;
      locked_r      <= 1'b0;
      seq_err_r     <= 1'b0;
      lap_r         <= {LAPW{1'b0}};
      err_r         <= 8'd0;
    end else begin
      state_r       <= state_s;
      ref_r         <= ref_s;
      good_r        <= good_s;
      index_r       <= index_s;
      index_valid_r <= index_valid_s;
      locked_r      <= locked_s;
      seq_err_r     <= seq_err_s;
      lap_r         <= lap_s;
      err_r         <= err_s;
    end
  end

  assign Index_out   = index_r;
  assign Index_valid = index_valid_r;
  assign Locked      = locked_r;
  assign Seq_err     = seq_err_r;
  assign Lap_count   = lap_r;
  assign Err_count   = err_r;

endmodule

// File: doc/ring_decoder.md
# ring_decoder

Receive-side companion to the team's one-hot ring counter. Accepts a sampled WIDTH-bit ring value, decodes it to a binary index, checks that successive samples follow the rotate-left ring sequence and reports lock, sequence errors and completed laps. Sits at the consumer end of any ring-counter bus, where it turns a one-hot phase into a usable index and monitors the ring's integrity.

## Interface
- WIDTH, 4, ring width in bits; must be at least 2.
- LOCK_N, 2, consecutive correct steps required to assert Locked; must be at least 1.
- LAPW, 8, width of Lap_count.
- IDXW, $clog2(WIDTH), index width; derived, not overridden.
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Valid_in  in  1  Ring_in is sampled on a rising edge only when high.
- Ring_in  in  WIDTH  ring value under test.
- Index_out  out  IDXW  bit position of the set bit in the last accepted one-hot sample.
- Index_valid  out  1  one-cycle pulse; Index_out was updated by a one-hot sample.
- Locked  out  1  high while the sequence is verified.
- Seq_err  out  1  one-cycle pulse on an error while locked.
- Lap_count  out  LAPW  number of locked wraps from index WIDTH-1 to 0; wraps modulo 2^LAPW.
- Err_count  out  8  total Seq_err events; saturates at 255.

## Operation
- A sample is one-hot when exactly one bit of Ring_in is set; its index is that bit's position. Bit 0 gives index 0.
- The expected next index is (ref + 1) mod WIDTH, where ref is the last accepted index. This matches a left-rotating ring.
- FSM states: SEARCH, ACQUIRE and LOCKED. The good-step counter spans 0..LOCK_N.
- SEARCH:
  - One-hot sample: ref = index, good = 0, go to ACQUIRE.
  - Non-one-hot sample: stay in SEARCH.
- ACQUIRE:
  - Expected index: good + 1 and ref = index. When good reaches LOCK_N, go to LOCKED.
  - Wrong one-hot index: ref = index, good = 0, stay in ACQUIRE.
  - Non-one-hot sample: go to SEARCH.
  - No Seq_err is raised in this state.
- LOCKED:
  - Expected index: ref = index. A step from WIDTH-1 to 0 increments Lap_count.
  - Wrong one-hot index, including a repeat of the same value: Seq_err, Err_count + 1, ref = index, good = 0, go to ACQUIRE.
  - Non-one-hot sample (0000, multi-hot): Seq_err, Err_count + 1, go to SEARCH. Index_out holds.
- Locked is 1 exactly when the state is LOCKED.
- Valid_in low: no state, ref, counter or output change, except that the Index_valid and Seq_err pulses return to 0.
- Err_count at 255 stays at 255. Lap_count at its maximum wraps to 0.

## Timing
- All outputs are registered. Latency is one cycle: the edge that samples Ring_in also updates Index_out, Index_valid, Locked, Seq_err, Lap_count and Err_count for that sample.
- Index_valid is high for exactly the cycle after each accepted one-hot sample. On back-to-back valid samples it stays high continuously.
- Seq_err is high for exactly one cycle per error event.
- Locked rises on the edge that captures the LOCK_N-th consecutive correct step. It falls on the edge that captures the erroneous sample.
- Reset_n low forces the following immediately, without waiting for a Clock edge:
  - Index_out 0, Index_valid 0, Locked 0, Seq_err 0, Lap_count 0, Err_count 0.
  - State SEARCH, ref 0, good 0.
- Deassertion of Reset_n is expected to be synchronised externally. The first sample is taken on the first rising edge with Reset_n high and Valid_in high.
- Reset mid-LOCKED discards all history. The ring must be reacquired from SEARCH.

## Test plan
- Clean sequence, WIDTH=4, LOCK_N=2: Valid_in held high with 0001, 0010, 0100, 1000, 0001.
  - Index_out is 0, 1, 2, 3, 0 with Index_valid high throughout.
  - Locked rises on the 0100 sample.
  - Lap_count becomes 1 on the final 0001. Err_count stays 0.
- Wrong step: while locked at 1000, feed 0100, then 1000, 0001.
  - Seq_err pulses once, Err_count = 1, Locked falls.
  - Index_out = 2, then 3, then 0.
  - Locked rises again on 0001. Lap_count does not increment on that 0001.
- Invalid pattern: while locked, feed 0110, then 0000.
  - One Seq_err, Err_count + 1, Index_valid 0, Index_out unchanged, state SEARCH.
  - 0000 in SEARCH raises no further error.
  - Then 0001, 0010, 0100 relocks.
- Gaps: locked sequence with Valid_in low for 3 cycles between 0010 and 0100, while Ring_in shows garbage.
  - No output change during the gap and no Seq_err.
  - Locked stays 1 and 0100 is accepted.
- Saturation: 300 alternating lock/error events (pattern 0001, 0010, 0100, 0100 repeated). Err_count ends at 255 and does not wrap.
- Asynchronous reset: assert Reset_n low mid-cycle while locked with Lap_count = 5. All outputs go to 0 before the next Clock edge, and relock requires LOCK_N + 1 valid samples.
